// File: rtl/instrumented_adder_sequencer_pkg.sv
// Shared types and defaults for the instrumented adder sequencer.
package instrumented_adder_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StRun,
    StReport
  } seq_state_e;

  localparam int unsigned DefaultWidth         = 32;
  localparam int unsigned DefaultTimeoutCycles = 1024;
  localparam int unsigned DefaultSettleCycles  = 2;

  // Width of a tap index for a given ring width; never below one bit.
  function automatic int unsigned bit_w(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/instrumented_adder_sequencer_timer.sv
// seq_cycle_timer: cycle counter shared by the settle hold and the run timeout.
// clear_i restarts from zero, enable_i advances; terminal_o flags count == limit_i.
module seq_cycle_timer #(
  parameter int unsigned CntW = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            enable_i,
  input  logic [CntW-1:0] limit_i,
  output logic [CntW-1:0] count_o,
  output logic            terminal_o
);

  logic [CntW-1:0] count_q;

  // Count register; clear has priority over enable.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i) begin
      count_q <= count_q + CntW'(1);
    end
  end

  // Terminal only counts while the timer is actually in use.
  always_comb begin
    count_o    = count_q;
    terminal_o = enable_i && (count_q == limit_i);
  end

endmodule

// File: rtl/instrumented_adder_sequencer.sv
// instrumented_adder_sequencer: programs operands and a one-hot ring tap, runs the
// instrumented adder, captures count/sum per tap and returns results via valid/ready.
// Optional build macro SEQ_SUM_CHECK_EN enables the internal sum check; without it
// res_sum_ok is tied high.
module instrumented_adder_sequencer
  import instrumented_adder_seq_pkg::*;
#(
  parameter int unsigned WIDTH          = DefaultWidth,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles,
  parameter int unsigned SETTLE_CYCLES  = DefaultSettleCycles,
  localparam int unsigned BitW          = bit_w(WIDTH)
) (
  input  logic             wb_clk_i,
  input  logic             reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_a,
  input  logic [WIDTH-1:0] cfg_b,
  input  logic [BitW-1:0]  cfg_first_bit,
  input  logic [BitW-1:0]  cfg_last_bit,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic [WIDTH-1:0] dut_ring_bit,
  output logic             dut_run,
  input  logic             dut_done,
  input  logic [31:0]      dut_count,
  input  logic [WIDTH-1:0] dut_sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [BitW-1:0]  res_bit,
  output logic [31:0]      res_count,
  output logic             res_timeout,
  output logic             res_sum_ok,
  output logic             busy
);

  seq_state_e       state_q, state_d;
  logic [BitW-1:0]  bit_q, bit_d, last_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [31:0]      count_q;
  logic             timeout_q;
  logic             latch_cfg, capture, capture_timeout;

  logic [31:0] timer_count, timer_limit;
  logic        timer_term, timer_clear, timer_en;
  logic        unused_timer_count;

  assign unused_timer_count = ^timer_count;

  // Timer limit follows the phase; restarted on every state change.
  always_comb begin
    timer_limit = (state_q == StSetup) ? 32'(SETTLE_CYCLES - 1) : 32'(TIMEOUT_CYCLES - 1);
    timer_en    = (state_q == StSetup) || (state_q == StRun);
    timer_clear = (state_d != state_q);
  end

  seq_cycle_timer #(
    .CntW(32)
  ) u_timer (
    .clk_i     (wb_clk_i),
    .rst_ni    (reset_n),
    .clear_i   (timer_clear),
    .enable_i  (timer_en),
    .limit_i   (timer_limit),
    .count_o   (timer_count),
    .terminal_o(timer_term)
  );

  // Next-state logic for the sweep FSM.
  always_comb begin
    state_d         = state_q;
    bit_d           = bit_q;
    latch_cfg       = 1'b0;
    capture         = 1'b0;
    capture_timeout = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cfg_valid) begin
          latch_cfg = 1'b1;
          bit_d     = cfg_first_bit;
          state_d   = StSetup;
        end
      end
      StSetup: begin
        if (timer_term) state_d = StRun;
      end
      StRun: begin
        // done beats a coincident timeout
        if (dut_done) begin
          capture = 1'b1;
          state_d = StReport;
        end else if (timer_term) begin
          capture         = 1'b1;
          capture_timeout = 1'b1;
          state_d         = StReport;
        end
      end
      StReport: begin
        if (res_ready) begin
          // >= also covers first > last (single shot); never step past WIDTH-1
          if (bit_q >= last_q || bit_q == BitW'(WIDTH - 1)) begin
            state_d = StIdle;
          end else begin
            bit_d   = bit_q + BitW'(1);
            state_d = StSetup;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, latched configuration and captured results.
  always_ff @(posedge wb_clk_i) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      bit_q     <= '0;
      last_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      if (latch_cfg) begin
        a_q    <= cfg_a;
        b_q    <= cfg_b;
        last_q <= cfg_last_bit;
      end
      if (capture) begin
        count_q   <= dut_count;
        timeout_q <= capture_timeout;
        if (!capture_timeout) sum_q <= dut_sum;
      end
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    cfg_ready    = (state_q == StIdle);
    busy         = (state_q != StIdle);
    dut_run      = (state_q == StRun);
    res_valid    = (state_q == StReport);
    dut_a        = a_q;
    dut_b        = b_q;
    dut_ring_bit = ((state_q == StSetup) || (state_q == StRun)) ?
                   (WIDTH'(1) << bit_q) : '0;
    res_bit      = bit_q;
    res_count    = count_q;
    res_timeout  = timeout_q;
  end

`ifdef SEQ_SUM_CHECK_EN
  logic [WIDTH-1:0] sum_exp;
  assign sum_exp    = a_q + b_q;
  assign res_sum_ok = res_valid && !timeout_q && (sum_q == sum_exp);
`else
  logic unused_sum;
  assign unused_sum = ^sum_q;
  assign res_sum_ok = 1'b1;
`endif

endmodule
